if_fetch_unit: RTL and testbench

Instruction-fetch stage of the five-stage summer CPU pipeline, directly upstream of the IF/ID pipeline register. It holds the program counter and drives the instruction-memory address. It selects the next PC from sequential, branch, jump, jump-register, exception and interrupt sources, and produces the PC+4 / instruction pair and the flush request consumed by IF/ID. Interrupt requests are latched and taken only in user mode, which is PC[31] = 0.

---
 rtl/cpu_pkg.sv | 29 ++
 rtl/pc_next_sel.sv | 58 +++++
 rtl/if_fetch_unit.sv | 109 ++++++++++
 tb/tb_if_fetch_unit.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the summer CPU fetch stage.
//   RESET_VEC / IRQ_VEC / EXC_VEC : default fixed PC entry points
//   NOP                           : instruction word injected while booting
//   fetch_state_e                 : fetch-stage state (boot cycle, normal running)
//   pc_plus4 / keep_kernel        : PC arithmetic that preserves the kernel bit (pc[31])
package cpu_pkg;

  localparam logic [31:0] RESET_VEC = 32'h8000_0000;
  localparam logic [31:0] IRQ_VEC   = 32'h8000_0004;
  localparam logic [31:0] EXC_VEC   = 32'h8000_0008;
  localparam logic [31:0] NOP       = 32'h0000_0000;

  typedef enum logic [0:0] {
    StBoot = 1'b0,
    StRun  = 1'b1
  } fetch_state_e;

  // Sequential successor; the increment wraps inside the low 31 bits so the
  // kernel bit can never be changed by falling through.
  function automatic logic [31:0] pc_plus4(logic [31:0] pc);
    return {pc[31], pc[30:0] + 31'd4};
  endfunction

  // Relative redirects (branch, jump) keep the current privilege level.
  function automatic logic [31:0] keep_kernel(logic [31:0] pc, logic [31:0] tgt);
    return (pc & 32'h8000_0000) | (tgt & 32'h7FFF_FFFF);
  endfunction

endpackage

// File: rtl/pc_next_sel.sv
// Combinational next-PC priority mux for the fetch stage.
// Inputs : run_i (fetch state is RUN), pc_i (current PC), stall_i, redirect
//          requests with targets (exception, branch, jr, jump), irq_pending_i.
// Outputs: next_pc_o (PC for the next cycle), flush_if_o (current fetch is
//          wrong-path), irq_take_o (interrupt is taken at the coming edge).
module pc_next_sel
  import cpu_pkg::*;
#(
  parameter logic [31:0] IrqVec = IRQ_VEC,
  parameter logic [31:0] ExcVec = EXC_VEC
) (
  input  logic        run_i,
  input  logic [31:0] pc_i,
  input  logic        stall_i,
  input  logic        exception_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  input  logic        jump_i,
  input  logic [31:0] jump_target_i,
  input  logic        jr_i,
  input  logic [31:0] jr_target_i,
  input  logic        irq_pending_i,
  output logic [31:0] next_pc_o,
  output logic        flush_if_o,
  output logic        irq_take_o
);

  logic redirect;

  always_comb begin
    redirect   = exception_i | branch_taken_i | jr_i | jump_i;
    // Interrupts are only taken in user mode and never on top of a stall or
    // another redirect, so the pending request simply waits.
    irq_take_o = run_i & irq_pending_i & ~pc_i[31] & ~stall_i & ~redirect;
    flush_if_o = run_i & (redirect | irq_take_o);

    next_pc_o = pc_i;
    if (run_i) begin
      if (exception_i) begin
        next_pc_o = ExcVec;
      end else if (branch_taken_i) begin
        next_pc_o = keep_kernel(pc_i, branch_target_i);
      end else if (jr_i) begin
        // Full-width target: the only path out of kernel mode.
        next_pc_o = jr_target_i;
      end else if (jump_i) begin
        next_pc_o = keep_kernel(pc_i, jump_target_i);
      end else if (irq_take_o) begin
        next_pc_o = IrqVec;
      end else if (stall_i) begin
        next_pc_o = pc_i;
      end else begin
        next_pc_o = pc_plus4(pc_i);
      end
    end
  end

endmodule

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: holds the PC, drives instruction memory and feeds
// the IF/ID register.
// Inputs : clk, rst (async, active low), stall, exception, branch_taken /
//          branch_target, jump / jump_target, jr / jr_target, irq (level),
//          imem_rdata (combinational ROM read of imem_addr).
// Outputs: imem_addr (= pc), pc_plus4_out, instr_out (nop while booting),
//          flush_if, irq_ack (one-cycle pulse per taken interrupt),
//          irq_epc (resume address of the last taken interrupt).
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] ResetVec = RESET_VEC,
  parameter logic [31:0] IrqVec   = IRQ_VEC,
  parameter logic [31:0] ExcVec   = EXC_VEC
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        exception,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        jump,
  input  logic [31:0] jump_target,
  input  logic        jr,
  input  logic [31:0] jr_target,
  input  logic        irq,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_plus4_out,
  output logic [31:0] instr_out,
  output logic        flush_if,
  output logic        irq_ack,
  output logic [31:0] irq_epc
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic         irq_pending_q, irq_pending_d;
  logic         irq_ack_q, irq_ack_d;
  logic [31:0]  irq_epc_q, irq_epc_d;

  logic         run;
  logic [31:0]  next_pc;
  logic         irq_take;

  assign run = (state_q == StRun);

  pc_next_sel #(
    .IrqVec (IrqVec),
    .ExcVec (ExcVec)
  ) u_pc_next_sel (
    .run_i           (run),
    .pc_i            (pc_q),
    .stall_i         (stall),
    .exception_i     (exception),
    .branch_taken_i  (branch_taken),
    .branch_target_i (branch_target),
    .jump_i          (jump),
    .jump_target_i   (jump_target),
    .jr_i            (jr),
    .jr_target_i     (jr_target),
    .irq_pending_i   (irq_pending_q),
    .next_pc_o       (next_pc),
    .flush_if_o      (flush_if),
    .irq_take_o      (irq_take)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StBoot:  state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_comb begin
    pc_d          = next_pc;
    // A new request is recorded even on the edge that takes an older one, so
    // a level irq still asserted after the take is not dropped.
    irq_pending_d = (irq_pending_q & ~irq_take) | irq;
    irq_ack_d     = irq_take;
    // The squashed fetch at pc is where the handler must resume.
    irq_epc_d     = irq_take ? pc_q : irq_epc_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StBoot;
      pc_q          <= ResetVec;
      irq_pending_q <= 1'b0;
      irq_ack_q     <= 1'b0;
      irq_epc_q     <= 32'h0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      irq_pending_q <= irq_pending_d;
      irq_ack_q     <= irq_ack_d;
      irq_epc_q     <= irq_epc_d;
    end
  end

  assign imem_addr    = pc_q;
  assign pc_plus4_out = pc_plus4(pc_q);
  assign instr_out    = run ? imem_rdata : NOP;
  assign irq_ack      = irq_ack_q;
  assign irq_epc      = irq_epc_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;

  localparam logic [31:0] K_RESET = 32'h8000_0000;
  localparam logic [31:0] K_IRQ   = 32'h8000_0004;
  localparam logic [31:0] K_EXC   = 32'h8000_0008;
  localparam logic [31:0] K_ROM   = 32'h1357_9BDF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        stall, exception, branch_taken, jump, jr, irq;
  logic [31:0] branch_target, jump_target, jr_target;
  logic [31:0] imem_addr, imem_rdata, pc_plus4_out, instr_out, irq_epc;
  logic        flush_if, irq_ack;

  always #5 clk = ~clk;

  // Asynchronous ROM: content derived from the address.
  assign imem_rdata = ~imem_addr ^ K_ROM;

  if_fetch_unit dut (
    .clk           (clk),
    .rst           (rst_n),
    .stall         (stall),
    .exception     (exception),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .jump          (jump),
    .jump_target   (jump_target),
    .jr            (jr),
    .jr_target     (jr_target),
    .irq           (irq),
    .imem_addr     (imem_addr),
    .imem_rdata    (imem_rdata),
    .pc_plus4_out  (pc_plus4_out),
    .instr_out     (instr_out),
    .flush_if      (flush_if),
    .irq_ack       (irq_ack),
    .irq_epc       (irq_epc)
  );

  int total = 0;
  int bad   = 0;

  // Reference model state.
  logic [31:0] m_pc, m_epc;
  bit          m_run, m_pend, m_ack;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc = K_RESET; m_run = 0; m_pend = 0; m_ack = 0; m_epc = 32'h0;
  endtask

  function automatic logic [31:0] seq_next(input logic [31:0] pc);
    return (pc & 32'h8000_0000) | ((pc + 32'd4) & 32'h7FFF_FFFF);
  endfunction

  task automatic drive(input bit st, input bit ex, input bit br, input logic [31:0] bt,
                       input bit jm, input logic [31:0] jt, input bit r,
                       input logic [31:0] rt, input bit ir);
    stall = st; exception = ex; branch_taken = br; branch_target = bt;
    jump = jm; jump_target = jt; jr = r; jr_target = rt; irq = ir;
  endtask

  task automatic idle();
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
  endtask

  task automatic check_outputs(input bit exp_flush);
    chk("imem_addr", imem_addr, m_pc);
    chk("instr_out", instr_out, m_run ? (~m_pc ^ K_ROM) : 32'h0);
    chk("pc_plus4_out", pc_plus4_out, seq_next(m_pc));
    chk("flush_if", {31'h0, flush_if}, {31'h0, exp_flush});
    chk("irq_ack", {31'h0, irq_ack}, {31'h0, m_ack});
    chk("irq_epc", irq_epc, m_epc);
  endtask

  // One clock: check outputs mid-cycle against the model, then advance both.
  task automatic cycle();
    bit          redir, take, fl;
    logic [31:0] nxt;
    @(negedge clk);
    redir = exception | branch_taken | jr | jump;
    take  = m_run && m_pend && !m_pc[31] && !stall && !redir;
    fl    = m_run && (redir || take);
    if (!m_run)            nxt = m_pc;
    else if (exception)    nxt = K_EXC;
    else if (branch_taken) nxt = (m_pc & 32'h8000_0000) | (branch_target & 32'h7FFF_FFFF);
    else if (jr)           nxt = jr_target;
    else if (jump)         nxt = (m_pc & 32'h8000_0000) | (jump_target & 32'h7FFF_FFFF);
    else if (take)         nxt = K_IRQ;
    else if (stall)        nxt = m_pc;
    else                   nxt = seq_next(m_pc);
    check_outputs(fl);
    @(posedge clk);
    if (take) m_epc = m_pc;
    m_ack  = take;
    m_pend = (m_pend && !take) || irq;
    m_pc   = nxt;
    m_run  = 1;
    #1;
  endtask

  task automatic go_jr(input logic [31:0] t);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 1, t, 0);
    cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs(0);
    rst_n = 1'b1;

    // Boot then sequential fetch.
    repeat (5) cycle();

    // Stall with a taken branch: branch wins, kernel bit from pc kept.
    go_jr(32'h0000_0100);
    drive(1, 0, 1, 32'h8000_0040, 0, 32'h0, 0, 32'h0, 0);
    cycle();
    idle();
    cycle();
    chk("branch_dest", imem_addr, 32'h0000_0044);

    // Exception and jump together.
    go_jr(32'h0000_0200);
    drive(0, 1, 0, 32'h0, 1, 32'h0000_0500, 0, 32'h0, 0);
    cycle();
    chk("exc_dest", imem_addr, K_EXC);

    // irq arrives in kernel mode, taken once back in user mode.
    go_jr(32'h8000_0010);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    cycle();
    go_jr(32'h0000_0300);
    idle();
    repeat (3) cycle();
    chk("irq_epc_directed", irq_epc, 32'h0000_0300);

    // Interrupt eligible during a stall: it waits.
    go_jr(32'h0000_0400);
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    cycle();
    drive(1, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 0);
    cycle();
    idle();
    repeat (3) cycle();

    // Sequential wrap in both privilege levels.
    go_jr(32'h7FFF_FFFC);
    idle();
    cycle();
    go_jr(32'hFFFF_FFFC);
    idle();
    repeat (2) cycle();

    // Asynchronous reset with an interrupt pending.
    go_jr(32'h8000_0100);
    drive(0, 0, 0, 32'h0, 0, 32'h0, 0, 32'h0, 1);
    cycle();
    idle();
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_outputs(0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (6) cycle();

    // Randomised traffic.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 99) < 15, $urandom_range(0, 99) < 4,
            $urandom_range(0, 99) < 8, $urandom,
            $urandom_range(0, 99) < 6, $urandom,
            $urandom_range(0, 99) < 6, $urandom,
            !m_pend && ($urandom_range(0, 99) < 10));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
